// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: arbitrates fetch/data requests onto one single-port BRAM with read-modify-write sub-word stores.
module mem_port_arbiter #(
    parameter int ADDR_W = 12
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_rdy,
    output logic              i_valid,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [3:0]        d_be,
    input  logic [31:0]       d_addr,
    input  logic [31:0]       d_wdata,
    output logic              d_rdy,
    output logic              d_valid,
    output logic [31:0]       d_rdata,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_din,
    input  logic [31:0]       mem_dout
);
    typedef enum logic [2:0] {IDLE, RD, RESP, MERGE, WR, ACK} state_t;
    state_t            state_q, state_d;
    logic              last_d_q, last_d_d;
    logic              is_d_q, is_d_d;
    logic              we_q, we_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              mem_we_q, mem_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [31:0]       mem_din_q, mem_din_d;
    logic              idle, gnt_data;
    logic [31:0]       merged;
    logic              unused_addr_bits;
    assign unused_addr_bits = ^{i_addr[31:ADDR_W+2], i_addr[1:0], d_addr[31:ADDR_W+2], d_addr[1:0]};
    always_comb begin
        for (int n = 0; n < 4; n++)
            merged[8*n +: 8] = be_q[n] ? wdata_q[8*n +: 8] : mem_dout[8*n +: 8];
    end
    always_comb begin
        idle     = state_q == IDLE;
        gnt_data = d_req & (~i_req | ~last_d_q);
        d_rdy    = idle & gnt_data;
        i_rdy    = idle & i_req & ~gnt_data;
        i_valid  = state_q == RESP && !is_d_q;
        d_valid  = (state_q == RESP && is_d_q) || state_q == WR || state_q == ACK;
        i_rdata  = i_valid ? mem_dout : 32'd0;
        d_rdata  = (state_q == RESP && is_d_q) ? mem_dout : 32'd0;
        state_d    = state_q;
        last_d_d   = last_d_q;
        is_d_d     = is_d_q;
        we_d       = we_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        mem_we_d   = mem_we_q;
        mem_addr_d = mem_addr_q;
        mem_din_d  = mem_din_q;
        case (state_q)
            IDLE: begin
                if (d_rdy) begin
                    last_d_d = 1'b1;
                    is_d_d   = 1'b1;
                    we_d     = d_we;
                    be_d     = d_be;
                    wdata_d  = d_wdata;
                    if (d_we && d_be == 4'h0) begin
                        state_d = ACK;
                    end else begin
                        mem_addr_d = d_addr[ADDR_W+1:2];
                        // Whole-word stores skip the read; everything else reads first.
                        state_d    = (d_we && d_be == 4'hf) ? WR : RD;
                        mem_we_d   = d_we && d_be == 4'hf;
                        mem_din_d  = (d_we && d_be == 4'hf) ? d_wdata : mem_din_q;
                    end
                end else if (i_rdy) begin
                    last_d_d   = 1'b0;
                    is_d_d     = 1'b0;
                    we_d       = 1'b0;
                    mem_addr_d = i_addr[ADDR_W+1:2];
                    state_d    = RD;
                end
            end
            RD: state_d = we_q ? MERGE : RESP;
            MERGE: begin
                mem_din_d = merged;
                mem_we_d  = 1'b1;
                state_d   = WR;
            end
            default: begin
                mem_we_d = 1'b0;
                state_d  = IDLE;
            end
        endcase
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            last_d_q   <= 1'b0;
            is_d_q     <= 1'b0;
            we_q       <= 1'b0;
            be_q       <= 4'h0;
            wdata_q    <= 32'd0;
            mem_we_q   <= 1'b0;
            mem_addr_q <= '0;
            mem_din_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            last_d_q   <= last_d_d;
            is_d_q     <= is_d_d;
            we_q       <= we_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            mem_we_q   <= mem_we_d;
            mem_addr_q <= mem_addr_d;
            mem_din_q  <= mem_din_d;
        end
    end
    assign mem_we   = mem_we_q;
    assign mem_addr = mem_addr_q;
    assign mem_din  = mem_din_q;
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: scoreboard bench for mem_port_arbiter against a behavioural single-port BRAM.
module tb_mem_port_arbiter;
    logic        clk = 1'b0;
    logic        rst_n, i_req, i_rdy, i_valid, d_req, d_we, d_rdy, d_valid, mem_we;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata, mem_din, mem_dout;
    logic [3:0]  d_be;
    logic [11:0] mem_addr;
    logic        bd_we;
    logic [11:0] bd_addr;
    logic [31:0] bd_data;
    logic [31:0] ram [0:4095];
    typedef struct {bit is_d; logic [31:0] data;} exp_t;
    exp_t exp_q[$];
    int n_checks = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_W(12)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req(i_req), .i_addr(i_addr), .i_rdy(i_rdy), .i_valid(i_valid), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdy(d_rdy), .d_valid(d_valid), .d_rdata(d_rdata),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // Registered-read RAM; the read register holds on write cycles. bd_* is a bench preload path.
    always @(posedge clk) begin
        if (bd_we) ram[bd_addr] <= bd_data;
        else if (mem_we) ram[mem_addr] <= mem_din;
        else mem_dout <= ram[mem_addr];
    end

    always @(negedge clk) begin
        exp_t e;
        logic [31:0] got;
        if (i_valid || d_valid) begin
            n_checks++;
            if (i_valid && d_valid) begin
                n_fail++;
                $display("FAIL both_valid i_valid=%b d_valid=%b required one", i_valid, d_valid);
            end else if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_valid i_valid=%b d_valid=%b with empty scoreboard", i_valid, d_valid);
            end else begin
                e = exp_q.pop_front();
                got = i_valid ? i_rdata : d_rdata;
                if (e.is_d !== d_valid || got !== e.data) begin
                    n_fail++;
                    $display("FAIL sb_resp got is_d=%b data=%h exp is_d=%b data=%h", d_valid, got, e.is_d, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic preload(input logic [11:0] a, input logic [31:0] v);
        bd_we = 1'b1; bd_addr = a; bd_data = v;
        tick();
        bd_we = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick();
        tick();
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rst_we got %b exp 0", mem_we); end
        n_checks++; if (mem_addr !== 12'd0) begin n_fail++; $display("FAIL rst_addr got %h exp 0", mem_addr); end
        n_checks++; if (mem_din !== 32'd0) begin n_fail++; $display("FAIL rst_din got %h exp 0", mem_din); end
        n_checks++; if ({i_valid, d_valid} !== 2'b00) begin n_fail++; $display("FAIL rst_valid got %b exp 00", {i_valid, d_valid}); end
        rst_n = 1'b1;
    endtask

    task automatic test_fetch();
        preload(12'd4, 32'hDEAD_BEEF);
        i_req = 1'b1; i_addr = 32'h0000_0010;
        #1;
        n_checks++; if (i_rdy !== 1'b1) begin n_fail++; $display("FAIL fetch_rdy got %b exp 1", i_rdy); end
        exp_q.push_back('{1'b0, 32'hDEAD_BEEF});
        tick();
        i_addr = 32'h0000_0FF0;
        #1;
        n_checks++; if (mem_addr !== 12'd4 || mem_we !== 1'b0) begin n_fail++; $display("FAIL fetch_rd got addr=%h we=%b exp addr=004 we=0", mem_addr, mem_we); end
        n_checks++; if (i_rdy !== 1'b0 || i_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_t1 got rdy=%b valid=%b exp 0 0", i_rdy, i_valid); end
        tick();
        n_checks++; if (i_valid !== 1'b1 || i_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL fetch_resp got valid=%b data=%h exp 1 deadbeef", i_valid, i_rdata); end
        n_checks++; if (i_rdy !== 1'b0) begin n_fail++; $display("FAIL fetch_t2_rdy got %b exp 0", i_rdy); end
        i_req = 1'b0;
        tick();
        n_checks++; if (i_valid !== 1'b0) begin n_fail++; $display("FAIL fetch_t3_valid got %b exp 0", i_valid); end
    endtask

    task automatic test_full_store_load();
        d_req = 1'b1; d_we = 1'b1; d_be = 4'hf; d_addr = 32'h20; d_wdata = 32'h1234_5678;
        #1;
        n_checks++; if (d_rdy !== 1'b1 || i_rdy !== 1'b0) begin n_fail++; $display("FAIL st_rdy got d=%b i=%b exp 1 0", d_rdy, i_rdy); end
        exp_q.push_back('{1'b1, 32'd0});
        tick();
        d_req = 1'b0; d_wdata = 32'hFFFF_FFFF; d_addr = 32'h0;
        n_checks++; if (mem_we !== 1'b1 || mem_addr !== 12'd8 || mem_din !== 32'h1234_5678) begin n_fail++; $display("FAIL st_wr got we=%b addr=%h din=%h exp 1 008 12345678", mem_we, mem_addr, mem_din); end
        n_checks++; if (d_valid !== 1'b1) begin n_fail++; $display("FAIL st_valid got %b exp 1", d_valid); end
        tick();
        n_checks++; if (mem_we !== 1'b0 || d_valid !== 1'b0) begin n_fail++; $display("FAIL st_t2 got we=%b valid=%b exp 0 0", mem_we, d_valid); end
        d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h20;
        #1;
        n_checks++; if (d_rdy !== 1'b1) begin n_fail++; $display("FAIL ld_rdy got %b exp 1", d_rdy); end
        exp_q.push_back('{1'b1, 32'h1234_5678});
        tick();
        d_req = 1'b0;
        n_checks++; if (mem_we !== 1'b0 || mem_addr !== 12'd8) begin n_fail++; $display("FAIL ld_rd got we=%b addr=%h exp 0 008", mem_we, mem_addr); end
        tick();
        n_checks++; if (d_valid !== 1'b1 || d_rdata !== 32'h1234_5678) begin n_fail++; $display("FAIL ld_resp got valid=%b data=%h exp 1 12345678", d_valid, d_rdata); end
        tick();
    endtask

    task automatic test_partial_store();
        preload(12'd8, 32'hAABB_CCDD);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0010; d_addr = 32'h20; d_wdata = 32'h0000_EE00;
        #1;
        n_checks++; if (d_rdy !== 1'b1) begin n_fail++; $display("FAIL ps_rdy got %b exp 1", d_rdy); end
        exp_q.push_back('{1'b1, 32'd0});
        tick();
        d_req = 1'b0; d_wdata = 32'h0; d_be = 4'hf;
        n_checks++; if (mem_we !== 1'b0 || mem_addr !== 12'd8 || d_valid !== 1'b0) begin n_fail++; $display("FAIL ps_t1 got we=%b addr=%h valid=%b exp 0 008 0", mem_we, mem_addr, d_valid); end
        tick();
        n_checks++; if (mem_we !== 1'b0 || d_valid !== 1'b0) begin n_fail++; $display("FAIL ps_t2 got we=%b valid=%b exp 0 0", mem_we, d_valid); end
        tick();
        n_checks++; if (mem_we !== 1'b1 || mem_din !== 32'hAABB_EEDD || d_valid !== 1'b1) begin n_fail++; $display("FAIL ps_t3 got we=%b din=%h valid=%b exp 1 aabbeedd 1", mem_we, mem_din, d_valid); end
        tick();
        n_checks++; if (mem_we !== 1'b0 || d_valid !== 1'b0) begin n_fail++; $display("FAIL ps_t4 got we=%b valid=%b exp 0 0", mem_we, d_valid); end
        n_checks++; if (ram[8] !== 32'hAABB_EEDD) begin n_fail++; $display("FAIL ps_ram got %h exp aabbeedd", ram[8]); end
    endtask

    task automatic test_contention();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        i_req = 1'b1; i_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_be = 4'h0; d_addr = 32'h20;
        for (int k = 0; k < 6; k++) begin
            #1;
            n_checks++;
            if (d_rdy !== (k % 2 == 0) || i_rdy !== (k % 2 == 1)) begin
                n_fail++;
                $display("FAIL arb_grant%0d got d_rdy=%b i_rdy=%b exp d_rdy=%b", k, d_rdy, i_rdy, k % 2 == 0);
            end
            exp_q.push_back(k % 2 == 0 ? '{1'b1, 32'hAABB_EEDD} : '{1'b0, 32'hDEAD_BEEF});
            tick();
            tick();
            tick();
        end
        i_req = 1'b0; d_req = 1'b0;
        tick();
    endtask

    task automatic test_null_store_wrap();
        preload(12'd1, 32'hCAFE_F00D);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'h0; d_addr = 32'h20; d_wdata = 32'h5555_5555;
        #1;
        n_checks++; if (d_rdy !== 1'b1) begin n_fail++; $display("FAIL ns_rdy got %b exp 1", d_rdy); end
        exp_q.push_back('{1'b1, 32'd0});
        tick();
        d_req = 1'b0;
        n_checks++; if (d_valid !== 1'b1 || mem_we !== 1'b0) begin n_fail++; $display("FAIL ns_t1 got valid=%b we=%b exp 1 0", d_valid, mem_we); end
        tick();
        n_checks++; if (d_valid !== 1'b0 || mem_we !== 1'b0) begin n_fail++; $display("FAIL ns_t2 got valid=%b we=%b exp 0 0", d_valid, mem_we); end
        n_checks++; if (ram[8] !== 32'hAABB_EEDD) begin n_fail++; $display("FAIL ns_ram got %h exp aabbeedd", ram[8]); end
        d_req = 1'b1; d_we = 1'b0; d_be = 4'hf; d_addr = 32'h0000_4004;
        #1;
        exp_q.push_back('{1'b1, 32'hCAFE_F00D});
        tick();
        d_req = 1'b0;
        n_checks++; if (mem_addr !== 12'd1) begin n_fail++; $display("FAIL wrap_addr got %h exp 001", mem_addr); end
        tick();
        tick();
    endtask

    task automatic test_reset_mid_rmw();
        preload(12'd8, 32'h1122_3344);
        d_req = 1'b1; d_we = 1'b1; d_be = 4'b0100; d_addr = 32'h20; d_wdata = 32'h0099_0000;
        #1;
        exp_q.push_back('{1'b1, 32'd0});
        tick();
        d_req = 1'b0;
        tick();
        rst_n = 1'b0;
        #1;
        n_checks++; if (mem_we !== 1'b0) begin n_fail++; $display("FAIL rmw_merge_we got %b exp 0", mem_we); end
        tick();
        exp_q.delete();
        rst_n = 1'b1;
        n_checks++; if (mem_we !== 1'b0 || d_valid !== 1'b0) begin n_fail++; $display("FAIL rmw_rst got we=%b valid=%b exp 0 0", mem_we, d_valid); end
        n_checks++; if (ram[8] !== 32'h1122_3344) begin n_fail++; $display("FAIL rmw_ram got %h exp 11223344", ram[8]); end
        d_req = 1'b1; d_we = 1'b0; d_addr = 32'h20;
        #1;
        n_checks++; if (d_rdy !== 1'b1) begin n_fail++; $display("FAIL rmw_idle_rdy got %b exp 1", d_rdy); end
        exp_q.push_back('{1'b1, 32'h1122_3344});
        tick();
        d_req = 1'b0;
        tick();
        tick();
        n_checks++; if (ram[8] !== 32'h1122_3344) begin n_fail++; $display("FAIL rmw_ram_after got %h exp 11223344", ram[8]); end
    endtask

    initial begin
        rst_n = 1'b0; i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_be = 4'h0;
        d_addr = 32'h0; d_wdata = 32'h0; bd_we = 1'b0; bd_addr = 12'h0; bd_data = 32'h0;
        test_reset();
        test_fetch();
        test_full_store_load();
        test_partial_store();
        test_contention();
        test_null_store_wrap();
        test_reset_mid_rmw();
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain got %0d pending exp 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
